regfile_wb: RTL and testbench
=============================

// Module: regfile_wb
// PURPOSE
//  Write-back end of the datapath: 32x32 MIPS general register file that accepts the word chosen by the
//  write-back source mux (ALU / memory / PC+4 / slt flag) and serves two operand read ports to decode.
//  Adds a load scoreboard: registers targeted by an in-flight load are marked pending until their
//  write-back lands; decode gets busy flags and a stall request. r0 is hardwired to zero.
// PARAMETERS
//  DATA_W    32  register width (bits)
//  ADDR_W    5   register address width; NREGS = 2**ADDR_W
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  regwrite   in   1       write-back strobe from control
//  waddr      in   ADDR_W  destination register of write-back
//  wdata      in   DATA_W  write-back data (output of source mux)
//  wb_is_load in   1       current write-back completes a load (memtoreg == 2'b01)
//  issue_load in   1       decode issues a load this cycle
//  load_rd    in   ADDR_W  destination of issued load
//  raddr1     in   ADDR_W  read port 1 address (rs)
//  raddr2     in   ADDR_W  read port 2 address (rt)
//  rdata1     out  DATA_W  read port 1 data
//  rdata2     out  DATA_W  read port 2 data
//  busy1      out  1       raddr1 pending a load
//  busy2      out  1       raddr2 pending a load
//  stall      out  1       busy1 | busy2
// BEHAVIOUR
//  - Reset: all registers := 0, pending vector := 0 on the first rising edge with rst=1; hence
//    rdata1/2=0, busy1/2=0, stall=0. rst overrides regwrite/issue_load in the same cycle.
//  - Write: at posedge, if regwrite && waddr!=0 then reg[waddr] := wdata. Writes to r0 are discarded.
//  - Read: combinational, zero latency. raddrN==0 -> rdataN=0 always.
//  - Scoreboard (pending[NREGS], bit 0 tied 0), updated at posedge:
//      clear pending[waddr] when regwrite && wb_is_load;
//      set pending[load_rd] when issue_load && load_rd!=0;
//      same register set and cleared in one cycle -> set wins (newer load owns it).
//    A non-load write-back (wb_is_load=0) never clears a pending bit.
//  - busyN = pending[raddrN] (combinational); stall = busy1|busy2. raddr 0 never busy.
//  - Width: no arithmetic; all data paths DATA_W, no truncation or extension.
// CONFIGURATION
//  WB_BYPASS_EN defined: same-cycle write->read forwarding. If regwrite && waddr!=0 && waddr==raddrN,
//   rdataN = wdata (not the old contents); if additionally wb_is_load, busyN = 0 that cycle.
//  WB_BYPASS_EN undefined: reads return stored contents only; new value visible the cycle after the
//   write edge; busyN reflects registered pending bits only (one extra stall cycle on load-use).
// STRUCTURE
//  Shared package: DATA_W/ADDR_W defaults, NREGS, REG_ZERO=0, write-back source codes
//   (WB_ALU=2'b00, WB_MEM=2'b01, WB_PC=2'b10, WB_SLT=2'b11) used to derive wb_is_load upstream.
//  Sub-module: regfile_scoreboard (pending vector, set/clear priority, busy lookup);
//   register array and read/bypass logic stay in regfile_wb.
// TESTING
//  1. rst=1 one cycle, then read all 32 addrs -> rdata=0, busy=0, stall=0.
//  2. Write 0xDEADBEEF to r5; next cycle raddr1=5 -> 0xDEADBEEF; write 0x1234 to r0 -> raddr2=0 reads 0.
//  3. issue_load load_rd=8; next cycle raddr1=8 -> busy1=1, stall=1; wb regwrite waddr=8 wb_is_load=1
//     wdata=0x55 -> with WB_BYPASS_EN same cycle rdata1=0x55,busy1=0; without: busy1 drops next cycle.
//  4. Same cycle: issue_load load_rd=9 and load write-back waddr=9 -> pending[9]=1 after edge (set wins).
//  5. Pending r10, ALU write-back (wb_is_load=0) to r10 -> busy remains 1; reg value updated.
//  6. Pending r3 and r4, assert rst mid-operation -> next cycle all busy=0, r3/r4 read 0.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared constants for the write-back register file and its load scoreboard.
// The WB_BYPASS_EN build macro enables same-cycle write-to-read forwarding.
package regfile_wb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int NREGS      = 2 ** DEF_ADDR_W;
  localparam int REG_ZERO   = 0;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC  = 2'b10,
    WB_SLT = 2'b11
  } wb_src_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Load scoreboard: one pending bit per register, set by an issued load,
// cleared when that load's write-back lands. A set in the same cycle wins.
module regfile_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr_en,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic              i_set_en,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic              o_busy1,
  output logic              o_busy2
);

  localparam int NR = 2 ** ADDR_W;

  logic [NR-1:0] r_pend;
  logic [NR-1:0] w_next;

  always_comb begin
    w_next = r_pend;
    if (i_clr_en) w_next[i_clr_addr] = 1'b0;
    if (i_set_en) w_next[i_set_addr] = 1'b1;
    w_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_pend <= '0;
    else     r_pend <= w_next;
  end

  assign o_busy1 = r_pend[i_raddr1];
  assign o_busy2 = r_pend[i_raddr2];

endmodule

// File: rtl/regfile_wb.sv
// 32x32 register file at the write-back end with a load scoreboard; r0 reads zero.
// Define WB_BYPASS_EN to forward the write-back word to same-cycle reads.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wb_is_load,
  input  logic              issue_load,
  input  logic [ADDR_W-1:0] load_rd,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy1,
  output logic              busy2,
  output logic              stall
);

  localparam int NR = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NR];
  logic              w_wen;
  logic              w_sb_busy1;
  logic              w_sb_busy2;
  logic              w_byp_clr1;
  logic              w_byp_clr2;

  assign w_wen = regwrite && (waddr != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) r_regs[i] <= '0;
    end else if (w_wen) begin
      r_regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = r_regs[raddr1];
    rdata2 = r_regs[raddr2];
    w_byp_clr1 = 1'b0;
    w_byp_clr2 = 1'b0;
`ifdef WB_BYPASS_EN
    if (w_wen && waddr == raddr1) begin
      rdata1     = wdata;
      w_byp_clr1 = wb_is_load;
    end
    if (w_wen && waddr == raddr2) begin
      rdata2     = wdata;
      w_byp_clr2 = wb_is_load;
    end
`endif
    if (raddr1 == ADDR_W'(REG_ZERO)) rdata1 = '0;
    if (raddr2 == ADDR_W'(REG_ZERO)) rdata2 = '0;
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_clr_en   (regwrite && wb_is_load),
    .i_clr_addr (waddr),
    .i_set_en   (issue_load && load_rd != ADDR_W'(REG_ZERO)),
    .i_set_addr (load_rd),
    .i_raddr1   (raddr1),
    .i_raddr2   (raddr2),
    .o_busy1    (w_sb_busy1),
    .o_busy2    (w_sb_busy2)
  );

  assign busy1 = w_sb_busy1 & ~w_byp_clr1;
  assign busy2 = w_sb_busy2 & ~w_byp_clr2;
  assign stall = busy1 | busy2;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: expected read results are queued as
// stimulus is driven and compared against the DUT mid-cycle.
module tb_regfile_wb;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        regwrite;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        wb_is_load;
  logic        issue_load;
  logic [4:0]  load_rd;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        busy1;
  logic        busy2;
  logic        stall;

  always #5 clk = ~clk;

  regfile_wb dut (
    .clk        (clk),
    .rst        (rst),
    .regwrite   (regwrite),
    .waddr      (waddr),
    .wdata      (wdata),
    .wb_is_load (wb_is_load),
    .issue_load (issue_load),
    .load_rd    (load_rd),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .busy1      (busy1),
    .busy2      (busy2),
    .stall      (stall)
  );

  typedef struct {
    string       tag;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    logic        st;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic push(input string tag, input logic [31:0] d1,
                      input logic [31:0] d2, input logic b1,
                      input logic b2);
    exp_t e;
    e.tag = tag;
    e.d1  = d1;
    e.d2  = d2;
    e.b1  = b1;
    e.b2  = b2;
    e.st  = b1 | b2;
    q.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    #1;
    if (q.size() == 0) begin
      n_bad++;
      $error("FAIL queue_empty observed=0 expected=1");
      return;
    end
    e = q.pop_front();
    n_vec++;
    assert (rdata1 === e.d1) else begin
      n_bad++;
      $error("FAIL %s rdata1 observed=%h expected=%h", e.tag, rdata1, e.d1);
    end
    assert (rdata2 === e.d2) else begin
      n_bad++;
      $error("FAIL %s rdata2 observed=%h expected=%h", e.tag, rdata2, e.d2);
    end
    assert (busy1 === e.b1) else begin
      n_bad++;
      $error("FAIL %s busy1 observed=%b expected=%b", e.tag, busy1, e.b1);
    end
    assert (busy2 === e.b2) else begin
      n_bad++;
      $error("FAIL %s busy2 observed=%b expected=%b", e.tag, busy2, e.b2);
    end
    assert (stall === e.st) else begin
      n_bad++;
      $error("FAIL %s stall observed=%b expected=%b", e.tag, stall, e.st);
    end
  endtask

  task automatic idle();
    rst        = 1'b0;
    regwrite   = 1'b0;
    waddr      = '0;
    wdata      = '0;
    wb_is_load = 1'b0;
    issue_load = 1'b0;
    load_rd    = '0;
  endtask

  initial begin
    idle();
    rst    = 1'b1;
    raddr1 = '0;
    raddr2 = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state across every address
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      push($sformatf("rst_a%0d", i), 32'h0, 32'h0, 1'b0, 1'b0);
      check();
      @(negedge clk);
    end

    // plain write, and r0 discard
    regwrite = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    raddr1 = 5'd5; raddr2 = 5'd0;
    push("wr5_same", BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 1'b0, 1'b0);
    check();
    @(negedge clk);
    waddr = 5'd0; wdata = 32'h1234;
    push("wr0_same", 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    check();
    @(negedge clk);
    idle();
    push("wr5_after", 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    check();

    // load r8, then its write-back
    issue_load = 1'b1; load_rd = 5'd8;
    raddr1 = 5'd8; raddr2 = 5'd5;
    push("ld8_issue", 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    check();
    @(negedge clk);
    idle();
    push("ld8_pend", 32'h0, 32'hDEADBEEF, 1'b1, 1'b0);
    check();
    @(negedge clk);
    regwrite = 1'b1; waddr = 5'd8; wdata = 32'h55; wb_is_load = 1'b1;
    push("ld8_wb", BYP ? 32'h55 : 32'h0, 32'hDEADBEEF, !BYP, 1'b0);
    check();
    @(negedge clk);
    idle();
    push("ld8_done", 32'h55, 32'hDEADBEEF, 1'b0, 1'b0);
    check();

    // set and clear of r9 in one cycle: set wins; load to r0 ignored
    issue_load = 1'b1; load_rd = 5'd9;
    regwrite = 1'b1; waddr = 5'd9; wdata = 32'h99; wb_is_load = 1'b1;
    raddr1 = 5'd9; raddr2 = 5'd8;
    push("r9_setclr", BYP ? 32'h99 : 32'h0, 32'h55, 1'b0, 1'b0);
    check();
    @(negedge clk);
    idle();
    issue_load = 1'b1; load_rd = 5'd0;
    push("r9_setwins", 32'h99, 32'h55, 1'b1, 1'b0);
    check();
    @(negedge clk);
    idle();
    raddr1 = 5'd0; raddr2 = 5'd9;
    push("r0_neverbusy", 32'h0, 32'h99, 1'b0, 1'b1);
    check();
    @(negedge clk);

    // ALU write-back does not clear a pending load
    issue_load = 1'b1; load_rd = 5'd10;
    raddr1 = 5'd10; raddr2 = 5'd9;
    push("ld10_issue", 32'h0, 32'h99, 1'b0, 1'b1);
    check();
    @(negedge clk);
    idle();
    regwrite = 1'b1; waddr = 5'd10; wdata = 32'hAAAA;
    push("alu10_wb", BYP ? 32'hAAAA : 32'h0, 32'h99, 1'b1, 1'b1);
    check();
    @(negedge clk);
    idle();
    push("alu10_after", 32'hAAAA, 32'h99, 1'b1, 1'b1);
    check();

    // reset mid-operation with r3/r4 pending
    regwrite = 1'b1; waddr = 5'd3; wdata = 32'h33;
    @(negedge clk);
    idle();
    issue_load = 1'b1; load_rd = 5'd3;
    @(negedge clk);
    load_rd = 5'd4;
    @(negedge clk);
    idle();
    raddr1 = 5'd3; raddr2 = 5'd4;
    push("r34_pend", 32'h33, 32'h0, 1'b1, 1'b1);
    check();
    rst = 1'b1;
    issue_load = 1'b1; load_rd = 5'd7;
    regwrite = 1'b1; waddr = 5'd4; wdata = 32'h44;
    push("rst_pre", 32'h33, BYP ? 32'h44 : 32'h0, 1'b1, 1'b1);
    check();
    @(negedge clk);
    idle();
    push("rst_post34", 32'h0, 32'h0, 1'b0, 1'b0);
    check();
    raddr1 = 5'd7; raddr2 = 5'd10;
    push("rst_post7_10", 32'h0, 32'h0, 1'b0, 1'b0);
    check();
    raddr1 = 5'd5; raddr2 = 5'd8;
    push("rst_post5_8", 32'h0, 32'h0, 1'b0, 1'b0);
    check();

    if (q.size() != 0) begin
      n_bad++;
      $error("FAIL queue_left observed=%0d expected=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
